// File: rtl/vga_stream_pkg.sv
// Shared definitions for the VGA stream: field positions, widths and the
// default 800x600@72 timing used by the generator and every drawing stage.
package vga_stream_pkg;

  // Stream field positions
  localparam int ACTIVE_BIT = 0;
  localparam int VS_BIT     = 1;
  localparam int HS_BIT     = 2;
  localparam int YC_LSB     = 3;
  localparam int YC_MSB     = 12;
  localparam int XC_LSB     = 13;
  localparam int XC_MSB     = 22;
  localparam int R_BIT      = 23;
  localparam int G_BIT      = 24;
  localparam int B_BIT      = 25;

  // Stream widths
  localparam int VGA_W = 23;
  localparam int RGB_W = 26;

  // Counter width; totals above 2048 do not fit
  localparam int CNT_W   = 11;
  localparam int CNT_MAX = 2048;

  // Default 800x600@72 timing (50 MHz pixel clock)
  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FRONT   = 56;
  localparam int DEF_H_SYNC    = 120;
  localparam int DEF_H_BACK    = 64;
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FRONT   = 37;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BACK    = 23;

  // Half-open window test lo <= v < hi on counter-width values
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter 0..TOTAL-1 with a terminal-count flag, used for both the
// horizontal (pixel) and vertical (line) axes.
module vga_axis_counter #(
  parameter int TOTAL = 1040,
  parameter int W     = 11
) (
  input  logic         px_clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign tc = (count == LAST);

  // Advance on enable, wrapping to zero after the last position
  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_stream_gen.sv
// VGA timing generator: counts pixels/lines and packs Active, VS, HS, YC and
// XC into the registered 23-bit stream consumed by the drawing stages.
module vga_stream_gen
  import vga_stream_pkg::*;
#(
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic HS_POL    = 1'b1,
  parameter logic VS_POL    = 1'b1
) (
  input  logic              px_clk,
  input  logic              rst_n,
  input  logic              ce,
  output logic [VGA_W-1:0]  strVGA,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_total_check
    $error("vga_stream_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
  end

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic             h_tc;
  logic             v_tc;
  logic             v_en;

  assign v_en = ce && h_tc;

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(CNT_W)) u_hcnt (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .en     (ce),
    .count  (hc),
    .tc     (h_tc)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .W(CNT_W)) u_vcnt (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .en     (v_en),
    .count  (vc),
    .tc     (v_tc)
  );

  logic active_s;
  logic hs_s;
  logic vs_s;
  logic line_s;
  logic frame_s;

  // Decode visible area, sync pulses and start markers from the current counters
  always_comb begin
    active_s = (hc < H_ACT_END) && (vc < V_ACT_END);
    hs_s     = in_window(hc, H_SYNC_BEG, H_SYNC_END) ? HS_POL : ~HS_POL;
    vs_s     = in_window(vc, V_SYNC_BEG, V_SYNC_END) ? VS_POL : ~VS_POL;
    line_s   = (hc == CNT_W'(0));
    frame_s  = (hc == CNT_W'(0)) && (vc == CNT_W'(0));
  end

  // Register the stream and pulses; everything holds while ce is low
  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      strVGA      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      strVGA      <= {hc[9:0], vc[9:0], hs_s, vs_s, active_s};
      line_start  <= line_s;
      frame_start <= frame_s;
    end
  end

endmodule

// File: tb/tb_vga_stream_gen.sv
// Self-checking bench for vga_stream_gen: directed scenarios plus random
// ce/reset traffic against a position-based reference model.
module tb_vga_stream_gen;

  // Default horizontal timing, shortened vertical timing so a full frame fits
  localparam int HV = 800, HF = 56, HSW = 120, HB = 64;
  localparam int VV = 20,  VF = 3,  VSW = 2,   VB = 2;
  localparam int HT = HV + HF + HSW + HB;   // 1040
  localparam int VT = VV + VF + VSW + VB;   // 27
  localparam logic HPOL = 1'b1;
  localparam logic VPOL = 1'b1;

  logic        px_clk;
  logic        rst_n;
  logic        ce;
  logic [22:0] strVGA;
  logic        line_start;
  logic        frame_start;

  vga_stream_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(HPOL), .VS_POL(VPOL)
  ) dut (
    .px_clk      (px_clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .strVGA      (strVGA),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint pos      = 0;     // enabled edges since reset; stream shows index pos-1
  int     vs_cnt   = 0;
  longint first_vs_idx = -1;
  int     first_vs_xc  = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (pos %0d)", tag, obs, exp, pos);
    end
  endtask

  // Expected stream for a given number of enabled edges since reset
  function automatic logic [22:0] exp_stream(input longint p);
    longint k, h, v;
    logic [31:0] hb, vb;
    logic act, hs, vs;
    if (p == 0) return 23'h0;
    k  = p - 1;
    h  = k % HT;
    v  = (k / HT) % VT;
    hb = 32'(h);
    vb = 32'(v);
    act = (h < HV) && (v < VV);
    hs  = (h >= HV + HF && h < HV + HF + HSW) ? HPOL : ~HPOL;
    vs  = (v >= VV + VF && v < VV + VF + VSW) ? VPOL : ~VPOL;
    return {hb[9:0], vb[9:0], hs, vs, act};
  endfunction

  function automatic logic exp_line(input longint p);
    if (p == 0) return 1'b0;
    return ((p - 1) % HT) == 0;
  endfunction

  function automatic logic exp_frame(input longint p);
    if (p == 0) return 1'b0;
    return ((p - 1) % (longint'(HT) * VT)) == 0;
  endfunction

  // One clock: apply inputs, advance the model, sample after the edge
  task automatic tick(input logic r, input logic c);
    rst_n = r;
    ce    = c;
    @(posedge px_clk);
    if (!r) pos = 0;
    else if (c) pos++;
    #1;
    check_eq("stream", 32'(strVGA), 32'(exp_stream(pos)));
    check_eq("line_start", 32'(line_start), 32'(exp_line(pos)));
    check_eq("frame_start", 32'(frame_start), 32'(exp_frame(pos)));
    if (r && c && strVGA[1] == VPOL) begin
      vs_cnt++;
      if (first_vs_idx < 0) begin
        first_vs_idx = pos - 1;
        first_vs_xc  = int'(strVGA[22:13]);
      end
    end
  endtask

  int first_hs, hs_cnt, guard;

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;

    // Reset hold
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1);
      check_eq("rst_stream", 32'(strVGA), 32'h0);
      check_eq("rst_pulses", {30'h0, line_start, frame_start}, 32'h0);
    end

    // First cycle after release
    vs_cnt = 0; first_vs_idx = -1;
    tick(1'b1, 1'b1);
    check_eq("first_stream", 32'(strVGA), 32'h000001);
    check_eq("first_frame_start", 32'(frame_start), 32'h1);
    check_eq("first_line_start", 32'(line_start), 32'h1);

    // First line: HS window position and width, aliased last pixel
    first_hs = -1; hs_cnt = 0;
    for (int i = 1; i < HT; i++) begin
      tick(1'b1, 1'b1);
      if (strVGA[2] == HPOL) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = i;
      end
      if (i == HT - 1) begin
        check_eq("last_px_xc", 32'(strVGA[22:13]), 32'd15);
        check_eq("last_px_active", 32'(strVGA[0]), 32'h0);
      end
    end
    check_eq("hs_first", 32'(first_hs), 32'd856);
    check_eq("hs_width", 32'(hs_cnt), 32'd120);

    // Line wrap
    tick(1'b1, 1'b1);
    check_eq("wrap_xc", 32'(strVGA[22:13]), 32'd0);
    check_eq("wrap_yc", 32'(strVGA[12:3]), 32'd1);
    check_eq("wrap_line_start", 32'(line_start), 32'h1);
    check_eq("wrap_frame_start", 32'(frame_start), 32'h0);

    // Frame wrap and VS window
    while (pos < longint'(HT) * VT + 1) tick(1'b1, 1'b1);
    check_eq("frame_wrap_fs", 32'(frame_start), 32'h1);
    check_eq("vs_cycles", 32'(vs_cnt), 32'(VSW * HT));
    check_eq("vs_first_idx", 32'(first_vs_idx), 32'((VV + VF) * HT));
    check_eq("vs_first_xc", 32'(first_vs_xc), 32'd0);

    // Stall at XC=400
    guard = 0;
    while (strVGA[22:13] != 10'd400 && guard < 2000) begin
      tick(1'b1, 1'b1);
      guard++;
    end
    check_eq("reach_xc400", 32'(guard < 2000), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      check_eq("stall_xc", 32'(strVGA[22:13]), 32'd400);
    end
    tick(1'b1, 1'b1);
    check_eq("resume_xc", 32'(strVGA[22:13]), 32'd401);

    // Mid-frame reset at YC=10, XC=500
    guard = 0;
    while (!(strVGA[12:3] == 10'd10 && strVGA[22:13] == 10'd500) && guard < 40000) begin
      tick(1'b1, 1'b1);
      guard++;
    end
    check_eq("reach_mid", 32'(guard < 40000), 32'h1);
    tick(1'b0, 1'b1);
    check_eq("midrst_stream", 32'(strVGA), 32'h0);
    check_eq("midrst_pulses", {30'h0, line_start, frame_start}, 32'h0);
    tick(1'b1, 1'b1);
    check_eq("midrst_release", 32'(strVGA), 32'h000001);
    check_eq("midrst_fs", 32'(frame_start), 32'h1);

    // Random ce stalls and occasional resets
    for (int i = 0; i < 20000; i++) begin
      tick(($urandom_range(0, 1499) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
